// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
//
// Pipelined carry look-ahead adder/subtractor. The WIDTH-bit operands are cut
// into STAGES equal segments; segment k is added in pipeline rank k using
// 4-bit CLA groups whose group generate/propagate terms produce the group
// carries. The carry out of each segment is registered into the next rank.
//
// Operand skew: every rank carries the full operand words forward, so upper
// segments arrive untouched at the rank that consumes them, and finished
// lower result segments ride along until the output, giving an aligned word.
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid & ready are both 1. The upstream side may not retract nothing - the
// block never looks at in_valid to form in_ready. The whole pipe advances as
// one when adv = out_ready | ~out_valid; in_ready is adv. While out_valid=1 and
// out_ready=0 every register holds, so the presented result stays stable.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operand handshake
//   in1, in2              operands A and B (WIDTH bits)
//   cin                   carry-in, add mode only
//   sub                   1: A - B, 0: A + B + cin
//   out_valid / out_ready result handshake
//   sum                   result, modulo 2^WIDTH
//   cout                  carry out of MSB (sub mode: 1 = no borrow)
//   ovf                   signed overflow
//
// WIDTH must be a multiple of 4*STAGES.
// -----------------------------------------------------------------------------
module cla_adder_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = WIDTH / STAGES;
  localparam int GRP = SEG / 4;

  // Result of one segment: sum bits, carry out of the segment, and the carry
  // into the segment's top bit (needed for overflow in the last rank).
  typedef struct packed {
    logic [SEG-1:0] s;
    logic           co;
    logic           cm;
  } seg_res_t;

  // Bit-level look-ahead inside one 4-bit group; c[0] is the group carry-in.
  function automatic logic [3:0] cla4_carry(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       c0);
    logic [3:0] c;
    c[0] = c0;
    c[1] = g[0] | (p[0] & c0);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // One segment: groups chained through group G/P, c(j+1) = G + P*c(j).
  function automatic seg_res_t seg_add(input logic [SEG-1:0] a,
                                       input logic [SEG-1:0] b,
                                       input logic           c0);
    seg_res_t   r;
    logic [GRP:0] gc;
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    logic       gg;
    logic       pp;
    r     = '0;
    gc    = '0;
    gc[0] = c0;
    for (int j = 0; j < GRP; j++) begin
      g  = a[j*4 +: 4] & b[j*4 +: 4];
      p  = a[j*4 +: 4] ^ b[j*4 +: 4];
      c  = cla4_carry(g, p, gc[j]);
      r.s[j*4 +: 4] = p ^ c;
      gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
      pp = &p;
      gc[j+1] = gg | (pp & gc[j]);
      // Last group overwrites this, leaving the carry into the segment MSB.
      r.cm = c[3];
    end
    r.co = gc[GRP];
    return r;
  endfunction

  // Subtraction is A + ~B + 1; the mode is folded into the stored operand
  // and the first-rank carry, so it travels with the item.
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  assign b_eff = sub ? ~in2 : in2;
  assign c_eff = sub | cin;

  // Pipeline ranks 0..STAGES-1; rank r holds segments 0..r of the result.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q;

  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] c_d;
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic              ovf_d;
  seg_res_t          seg_r [STAGES];

  logic adv;
  assign adv      = out_ready | ~v_q[STAGES-1];
  assign in_ready = adv;

  always_comb begin
    v_d   = '0;
    c_d   = '0;
    ovf_d = 1'b0;
    for (int r = 0; r < STAGES; r++) begin
      a_d[r]   = '0;
      b_d[r]   = '0;
      s_d[r]   = '0;
      seg_r[r] = '0;
    end

    // Rank 0 adds segment 0 straight from the operand inputs.
    seg_r[0]           = seg_add(in1[SEG-1:0], b_eff[SEG-1:0], c_eff);
    v_d[0]             = in_valid;
    a_d[0]             = in1;
    b_d[0]             = b_eff;
    s_d[0][SEG-1:0]    = seg_r[0].s;
    c_d[0]             = seg_r[0].co;

    for (int r = 1; r < STAGES; r++) begin
      seg_r[r] = seg_add(a_q[r-1][r*SEG +: SEG], b_q[r-1][r*SEG +: SEG],
                         c_q[r-1]);
      v_d[r]   = v_q[r-1];
      a_d[r]   = a_q[r-1];
      b_d[r]   = b_q[r-1];
      s_d[r]   = s_q[r-1];
      s_d[r][r*SEG +: SEG] = seg_r[r].s;
      c_d[r]   = seg_r[r].co;
    end

    ovf_d = seg_r[STAGES-1].co ^ seg_r[STAGES-1].cm;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int r = 0; r < STAGES; r++) begin
        a_q[r] <= '0;
        b_q[r] <= '0;
        s_q[r] <= '0;
      end
    end else if (adv) begin
      v_q   <= v_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int r = 0; r < STAGES; r++) begin
        a_q[r] <= a_d[r];
        b_q[r] <= b_d[r];
        s_q[r] <= s_d[r];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule
